hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined MIPS core. It sits beside the ID stage and tracks the destination register of every in-flight instruction in a shift-register scoreboard with one entry per post-ID stage. From that it produces forwarding selects, load-use stalls, branch flushes and a memory-wait freeze. It adds two things to the fixed EX/MEM decode logic: configurable pipeline depth and load latency, and a sequential memory-ready wait/timeout FSM.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_match.sv | 28 ++
 rtl/hazard_scoreboard.sv | 146 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: FSM state, scoreboard entry, select width.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } hz_state_t;

  // Entries carry a fixed-width destination; narrower register addresses are zero-extended.
  localparam int unsigned SB_DEST_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 is_load;
  } sb_entry_t;

  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Lowest-index producer search over the scoreboard for one source operand.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input  sb_entry_t [NUM_STAGES:1] i_entries,
  input  logic [REG_ADDR_W-1:0]    i_src,
  input  logic                     i_use,
  output logic [SEL_W-1:0]         o_sel,
  output logic                     o_is_load
);

  // Scan from the oldest entry down so the nearest producer overwrites older hits.
  always_comb begin
    o_sel     = '0;
    o_is_load = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (i_use && i_entries[k].valid && (i_entries[k].dest == SB_DEST_W'(i_src))) begin
        o_sel     = SEL_W'(k);
        o_is_load = i_entries[k].is_load;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: destination scoreboard, load-use stall, flush, memory-wait freeze.
//   state       | meaning
//   ST_RUN      | normal flow; a not-ready memory access freezes and enters MEM_WAIT
//   ST_MEM_WAIT | counting consecutive not-ready cycles toward the timeout
//   ST_FAULT    | memory timed out; pipeline frozen until reset
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int NUM_STAGES  = 3,
  parameter int LOAD_READY  = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int SEL_W       = sel_width(NUM_STAGES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_use_rs,
  input  logic                  i_id_use_rt,
  input  logic                  i_id_wr_en,
  input  logic [REG_ADDR_W-1:0] i_id_wr_addr,
  input  logic                  i_id_is_load,
  input  logic                  i_id_is_store,
  input  logic                  i_redirect,
  input  logic                  i_mem_access,
  input  logic                  i_mio_ready,
  output logic                  o_stall_if_id,
  output logic                  o_freeze,
  output logic                  o_flush_if,
  output logic [SEL_W-1:0]      o_fwd_rs_sel,
  output logic [SEL_W-1:0]      o_fwd_rt_sel,
  output logic                  o_fwd_rt_late,
  output logic                  o_mem_timeout,
  output logic [15:0]           o_stall_count
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  sb_entry_t [NUM_STAGES:1] r_sb;
  hz_state_t                r_state;
  logic [CNT_W-1:0]         r_wait_cnt;
  logic [15:0]              r_stall_count;

  logic [SEL_W-1:0] w_rs_sel;
  logic [SEL_W-1:0] w_rt_raw;
  logic             w_rs_load;
  logic             w_rt_load;
  logic             w_rs_stall;
  logic             w_rt_stall;
  logic             w_rt_late;
  logic             w_freeze;
  logic             w_stall;
  logic             w_flush;
  logic             w_mem_wait;
  sb_entry_t        w_id_entry;

  hazard_match #(.NUM_STAGES(NUM_STAGES), .REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) u_match_rs (
    .i_entries (r_sb),
    .i_src     (i_id_rs),
    .i_use     (i_id_use_rs),
    .o_sel     (w_rs_sel),
    .o_is_load (w_rs_load)
  );

  hazard_match #(.NUM_STAGES(NUM_STAGES), .REG_ADDR_W(REG_ADDR_W), .SEL_W(SEL_W)) u_match_rt (
    .i_entries (r_sb),
    .i_src     (i_id_rt),
    .i_use     (i_id_use_rt),
    .o_sel     (w_rt_raw),
    .o_is_load (w_rt_load)
  );

  // A store whose data comes from a load one entry short of ready takes it late at MEM instead of stalling.
  assign w_rt_late  = w_rt_load && i_id_is_store && (int'(w_rt_raw) == LOAD_READY - 1);
  assign w_rs_stall = w_rs_load && (int'(w_rs_sel) < LOAD_READY);
  assign w_rt_stall = w_rt_load && (int'(w_rt_raw) < LOAD_READY) && !w_rt_late;

  assign w_mem_wait = i_mem_access && !i_mio_ready;
  assign w_freeze   = (r_state == ST_FAULT) || w_mem_wait;
  assign w_stall    = i_id_valid && (w_rs_stall || w_rt_stall) && !w_freeze;
  assign w_flush    = i_redirect && !w_stall && !w_freeze;

  assign w_id_entry.valid   = i_id_valid && i_id_wr_en && (i_id_wr_addr != '0);
  assign w_id_entry.dest    = SB_DEST_W'(i_id_wr_addr);
  assign w_id_entry.is_load = i_id_is_load;

  // Outputs are forced low while reset is held, regardless of the inputs.
  assign o_stall_if_id = !i_rst && w_stall;
  assign o_freeze      = !i_rst && w_freeze;
  assign o_flush_if    = !i_rst && w_flush;
  assign o_fwd_rs_sel  = i_rst ? '0 : w_rs_sel;
  assign o_fwd_rt_sel  = (i_rst || w_rt_late) ? '0 : w_rt_raw;
  assign o_fwd_rt_late = !i_rst && w_rt_late;
  assign o_mem_timeout = !i_rst && (r_state == ST_FAULT);
  assign o_stall_count = r_stall_count;

  // Scoreboard shift: hold on freeze, insert a bubble on stall, else record the ID destination.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sb <= '0;
    end else if (!w_freeze) begin
      r_sb[NUM_STAGES:2] <= r_sb[NUM_STAGES-1:1];
      r_sb[1]            <= w_stall ? '0 : w_id_entry;
    end
  end

  // Memory-ready wait FSM with consecutive not-ready timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_wait) begin
            r_state    <= (MEM_TIMEOUT <= 1) ? ST_FAULT : ST_MEM_WAIT;
            r_wait_cnt <= CNT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (i_mio_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            if ((r_wait_cnt + CNT_W'(1)) == CNT_W'(MEM_TIMEOUT)) r_state <= ST_FAULT;
          end
        end
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  // Saturating count of cycles lost to stall or freeze.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_count <= '0;
    end else if ((w_stall || w_freeze) && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an in-flight instruction model and per-cycle compare.
module tb_hazard_scoreboard;

  localparam int RW = 5;
  localparam int NS = 3;
  localparam int LR = 2;
  localparam int TO = 15;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_is_store;
  logic [RW-1:0] id_rs, id_rt, id_wr_addr;
  logic          redirect, mem_access, mio_ready;
  logic          stall_if_id, freeze, flush_if, fwd_rt_late, mem_timeout;
  logic [SW-1:0] fwd_rs_sel, fwd_rt_sel;
  logic [15:0]   stall_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_W(RW), .NUM_STAGES(NS), .LOAD_READY(LR), .MEM_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt), .i_id_wr_en(id_wr_en),
    .i_id_wr_addr(id_wr_addr), .i_id_is_load(id_is_load), .i_id_is_store(id_is_store),
    .i_redirect(redirect), .i_mem_access(mem_access), .i_mio_ready(mio_ready),
    .o_stall_if_id(stall_if_id), .o_freeze(freeze), .o_flush_if(flush_if),
    .o_fwd_rs_sel(fwd_rs_sel), .o_fwd_rt_sel(fwd_rt_sel), .o_fwd_rt_late(fwd_rt_late),
    .o_mem_timeout(mem_timeout), .o_stall_count(stall_count)
  );

  // Model: in-flight instructions by stage (index 0 unused), memory-wait run length, fault flag.
  bit m_v [0:NS];
  int m_d [0:NS];
  bit m_l [0:NS];
  int m_nr;
  bit m_fault;
  int m_cnt;

  int e_rs, e_rt;
  bit e_stall, e_freeze, e_flush, e_late, e_to;

  always_comb begin
    int  krs, krt;
    bit  rs_st, rt_st, late;
    krs = 0;
    krt = 0;
    for (int k = 1; k <= NS; k++) begin
      if (krs == 0 && m_v[k] && m_d[k] == int'(id_rs)) krs = k;
      if (krt == 0 && m_v[k] && m_d[k] == int'(id_rt)) krt = k;
    end
    if (id_use_rs !== 1'b1) krs = 0;
    if (id_use_rt !== 1'b1) krt = 0;
    rs_st    = (krs != 0) && m_l[krs] && (krs < LR);
    late     = (id_is_store === 1'b1) && (krt != 0) && m_l[krt] && (krt == LR - 1);
    rt_st    = (krt != 0) && m_l[krt] && (krt < LR) && !late;
    e_freeze = m_fault || (mem_access === 1'b1 && mio_ready !== 1'b1);
    e_stall  = (id_valid === 1'b1) && (rs_st || rt_st) && !e_freeze;
    e_flush  = (redirect === 1'b1) && !e_stall && !e_freeze;
    e_rs     = krs;
    e_rt     = late ? 0 : krt;
    e_late   = late;
    e_to     = m_fault;
    if (rst !== 1'b0) begin
      e_rs = 0; e_rt = 0; e_stall = 0; e_freeze = 0; e_flush = 0; e_late = 0; e_to = 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= NS; k++) begin
        m_v[k] <= 1'b0; m_d[k] <= 0; m_l[k] <= 1'b0;
      end
      m_nr <= 0; m_fault <= 1'b0; m_cnt <= 0;
    end else begin
      if (!e_freeze) begin
        for (int k = NS; k >= 2; k--) begin
          m_v[k] <= m_v[k-1]; m_d[k] <= m_d[k-1]; m_l[k] <= m_l[k-1];
        end
        m_v[1] <= !e_stall && id_valid && id_wr_en && (id_wr_addr != '0);
        m_d[1] <= int'(id_wr_addr);
        m_l[1] <= id_is_load;
      end
      if (!m_fault) begin
        if (mem_access && !mio_ready) begin
          m_nr <= m_nr + 1;
          if (m_nr + 1 >= TO) m_fault <= 1'b1;
        end else begin
          m_nr <= 0;
        end
      end
      if ((e_stall || e_freeze) && m_cnt < 65535) m_cnt <= m_cnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("stall_if_id", 32'(stall_if_id), 32'(e_stall));
    chk("freeze",      32'(freeze),      32'(e_freeze));
    chk("flush_if",    32'(flush_if),    32'(e_flush));
    chk("fwd_rs_sel",  32'(fwd_rs_sel),  32'(e_rs));
    chk("fwd_rt_sel",  32'(fwd_rt_sel),  32'(e_rt));
    chk("fwd_rt_late", 32'(fwd_rt_late), 32'(e_late));
    chk("mem_timeout", 32'(mem_timeout), 32'(e_to));
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
  end

  task automatic idle_in();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_wr_en = 0; id_is_load = 0; id_is_store = 0;
    id_rs = '0; id_rt = '0; id_wr_addr = '0; redirect = 0; mem_access = 0; mio_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [RW-1:0] dst, input logic ld);
    idle_in();
    id_valid = 1; id_wr_en = 1; id_wr_addr = dst; id_is_load = ld;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_in();
    mem_access = 1; id_valid = 1; redirect = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_freeze", 32'(freeze), 0);
    chk("rst_flush",  32'(flush_if), 0);
    chk("rst_count",  32'(stall_count), 0);
    idle_in();
    rst = 0;
    #1;
    chk("post_rst_stall", 32'(stall_if_id), 0);
    tick();

    // load $2 in EX, consumer of $2 in ID
    issue(5'd2, 1'b1); tick();
    issue(5'd5, 1'b0); id_rs = 5'd2; id_use_rs = 1; #1;
    chk("lu_stall", 32'(stall_if_id), 1);
    chk("lu_sel_ex", 32'(fwd_rs_sel), 1);
    tick(); #1;
    chk("lu_stall_end", 32'(stall_if_id), 0);
    chk("lu_sel_mem", 32'(fwd_rs_sel), 2);
    tick();
    idle_in(); repeat (3) tick();

    // two producers of $3, nearest wins
    issue(5'd3, 1'b0); tick(); tick();
    idle_in(); id_valid = 1; id_rt = 5'd3; id_use_rt = 1; #1;
    chk("near_rt_sel", 32'(fwd_rt_sel), 1);
    chk("near_stall", 32'(stall_if_id), 0);
    tick();
    idle_in(); repeat (3) tick();

    // load $4 then store: data via rt goes late, address via rs stalls
    issue(5'd4, 1'b1); tick();
    idle_in(); id_valid = 1; id_is_store = 1; id_rt = 5'd4; id_use_rt = 1; id_use_rs = 1; #1;
    chk("sw_rt_stall", 32'(stall_if_id), 0);
    chk("sw_rt_late", 32'(fwd_rt_late), 1);
    chk("sw_rt_sel", 32'(fwd_rt_sel), 0);
    id_rs = 5'd4; id_rt = 5'd9; #1;
    chk("sw_rs_stall", 32'(stall_if_id), 1);
    chk("sw_rs_sel", 32'(fwd_rs_sel), 1);
    chk("sw_rs_late", 32'(fwd_rt_late), 0);
    tick();
    idle_in(); repeat (3) tick();

    // taken branch waiting on a load
    issue(5'd6, 1'b1); tick();
    idle_in(); id_valid = 1; id_rs = 5'd6; id_use_rs = 1; redirect = 1; #1;
    chk("br_stall", 32'(stall_if_id), 1);
    chk("br_flush_held", 32'(flush_if), 0);
    tick(); #1;
    chk("br_flush", 32'(flush_if), 1);
    tick();
    idle_in(); repeat (3) tick();

    // three not-ready memory cycles
    issue(5'd7, 1'b0); tick();
    issue(5'd8, 1'b0); id_rs = 5'd7; id_use_rs = 1; mem_access = 1; #1;
    chk("frz_count_before", 32'(stall_count), 3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_on", 32'(freeze), 1);
      chk("frz_held_sel", 32'(fwd_rs_sel), 1);
      tick();
    end
    mio_ready = 1; #1;
    chk("frz_drop", 32'(freeze), 0);
    chk("frz_sel_after", 32'(fwd_rs_sel), 1);
    chk("frz_count_after", 32'(stall_count), 6);
    tick();
    idle_in(); repeat (3) tick();

    // timeout
    idle_in(); mem_access = 1;
    repeat (14) tick();
    #1;
    chk("to_not_yet", 32'(mem_timeout), 0);
    tick(); #1;
    chk("to_set", 32'(mem_timeout), 1);
    mem_access = 0; mio_ready = 1; #1;
    chk("to_sticky", 32'(mem_timeout), 1);
    chk("to_freeze", 32'(freeze), 1);
    repeat (3) tick();
    chk("to_sticky_later", 32'(mem_timeout), 1);

    repeat (65540) tick();
    chk("count_sat", 32'(stall_count), 32'hFFFF);

    // reset out of FAULT
    rst = 1; #1;
    chk("rst_to", 32'(mem_timeout), 0);
    chk("rst_frz", 32'(freeze), 0);
    chk("rst_cnt_clr", 32'(stall_count), 0);
    tick();
    idle_in(); rst = 0; tick();
    chk("after_rst_to", 32'(mem_timeout), 0);

    // reset mid-wait
    mem_access = 1; repeat (4) tick();
    rst = 1; tick();
    rst = 0; tick(); #1;
    chk("midwait_freeze", 32'(freeze), 1);
    chk("midwait_to", 32'(mem_timeout), 0);
    tick();
    idle_in(); repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
